// File: rtl/dac_spi_driver_if.sv
// Bus between the sample source and the DAC SPI driver: sample/gain inputs,
// SPI pins and status flags.
interface dac_spi_driver_if;
    logic        enable;
    logic [31:0] signal;
    logic [7:0]  gain;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        busy;
    logic        sample_tick;
    logic        overrun;

    // Upstream side: supplies samples, observes the SPI pins and status.
    modport master (
        output enable, signal, gain,
        input  sclk, mosi, cs_n, busy, sample_tick, overrun
    );

    // Driver side.
    modport slave (
        input  enable, signal, gain,
        output sclk, mosi, cs_n, busy, sample_tick, overrun
    );
endinterface

// File: rtl/dac_spi_driver.sv
// Decimates the waveform sample stream, applies a saturating Q1.7 gain and
// ships each code to an SPI DAC as one {command, code} frame (mode 0, MSB first).
module dac_spi_driver #(
    parameter int                  DAC_BITS      = 12,
    parameter int                  CMD_BITS      = 4,
    parameter logic [CMD_BITS-1:0] CMD_VALUE     = 4'b0011,
    parameter int                  CLK_DIV       = 2,
    parameter int                  SAMPLE_PERIOD = 100,
    parameter int                  CS_GAP        = 2
) (
    input logic             clk,
    input logic             rst,
    dac_spi_driver_if.slave bus
);

    localparam int FRAME_BITS = CMD_BITS + DAC_BITS;
    localparam int CNT_W      = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int GAP_W      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  tick;
    logic                  overrun;
    logic [FRAME_BITS-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  sclk;
    logic                  mosi;
    logic                  cs_n;

    logic [DAC_BITS-1:0]   code;
    logic [DAC_BITS+7:0]   prod;
    logic [DAC_BITS:0]     scaled;
    logic [DAC_BITS-1:0]   sat_code;
    logic [FRAME_BITS-1:0] frame;
    logic                  sig_unused;

    // Scaling path: top DAC_BITS of the sample times Q1.7 gain, clipped to full scale.
    assign code       = bus.signal[31 -: DAC_BITS];
    assign prod       = {8'b0, code} * {{DAC_BITS{1'b0}}, bus.gain};
    assign scaled     = prod[DAC_BITS+7:7];
    assign sat_code   = scaled[DAC_BITS] ? '1 : scaled[DAC_BITS-1:0];
    assign frame      = {CMD_VALUE, sat_code};
    assign sig_unused = ^{bus.signal[31-DAC_BITS:0], prod[6:0]};

    // Sample-rate divider; tick is registered so it is high for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(SAMPLE_PERIOD - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

    // Sticky overrun: a tick that finds the shifter busy is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst)
            overrun <= 1'b0;
        else if (tick && state != S_IDLE)
            overrun <= 1'b1;
    end

    // Frame FSM: load on tick, toggle sclk every CLK_DIV cycles, shift on falling edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    sclk <= 1'b0;
                    cs_n <= 1'b1;
                    if (tick) begin
                        shreg   <= frame;
                        mosi    <= frame[FRAME_BITS-1];
                        cs_n    <= 1'b0;
                        bit_cnt <= BIT_W'(FRAME_BITS);
                        div_cnt <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // sclk currently high -> this is a falling edge: present next bit
                        if (sclk) begin
                            shreg   <= shreg << 1;
                            mosi    <= shreg[FRAME_BITS-2];
                            bit_cnt <= bit_cnt - 1'b1;
                            if (bit_cnt == BIT_W'(1)) begin
                                cs_n    <= 1'b1;
                                mosi    <= 1'b0;
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(CS_GAP - 1))
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sclk        = sclk;
    assign bus.mosi        = mosi;
    assign bus.cs_n        = cs_n;
    assign bus.busy        = (state != S_IDLE);
    assign bus.sample_tick = tick;
    assign bus.overrun     = overrun;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: a default instance for timing/frame/reset/enable
// behaviour and a fast-sampling instance (period 32) for overrun.
module tb_dac_spi_driver;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic rnd = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dac_spi_driver_if ifa ();
    dac_spi_driver_if ifb ();

    dac_spi_driver dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    dac_spi_driver #(.SAMPLE_PERIOD(32)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    // SPI receiver model per instance: captures mosi on sclk rising edges while cs_n low.
    logic [1:0] m_sclk, m_mosi, m_cs, m_busy;
    logic [1:0] p_sclk = 2'b00, p_mosi = 2'b00, p_cs = 2'b11;
    logic [15:0] cap [2];
    logic [15:0] last_frame [2];
    int cs_len [2] = '{0, 0};
    int nbits [2] = '{0, 0};
    int last_len [2] = '{0, 0};
    int last_bits [2] = '{0, 0};
    int nframes [2] = '{0, 0};
    int gap_len [2] = '{0, 0};
    int rises [2] = '{0, 0};
    int viol [2] = '{0, 0};

    assign m_sclk = {ifb.sclk, ifa.sclk};
    assign m_mosi = {ifb.mosi, ifa.mosi};
    assign m_cs   = {ifb.cs_n, ifa.cs_n};
    assign m_busy = {ifb.busy, ifa.busy};

    // Observe the pins on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_sclk[i] === 1'b1 && p_sclk[i] === 1'b0) rises[i] <= rises[i] + 1;
            if (m_sclk[i] === 1'b1 && p_sclk[i] === 1'b1 && m_mosi[i] !== p_mosi[i])
                viol[i] <= viol[i] + 1;
            if (m_cs[i] === 1'b0) begin
                cs_len[i] <= p_cs[i] ? 1 : cs_len[i] + 1;
                if (m_sclk[i] === 1'b1 && p_sclk[i] === 1'b0) begin
                    cap[i]   <= {(p_cs[i] ? 15'b0 : cap[i][14:0]), m_mosi[i]};
                    nbits[i] <= p_cs[i] ? 1 : nbits[i] + 1;
                end else if (p_cs[i]) begin
                    cap[i]   <= '0;
                    nbits[i] <= 0;
                end
            end else if (m_cs[i] === 1'b1 && p_cs[i] === 1'b0) begin
                last_frame[i] <= cap[i];
                last_len[i]   <= cs_len[i];
                last_bits[i]  <= nbits[i];
                nframes[i]    <= nframes[i] + 1;
                gap_len[i]    <= (m_busy[i] === 1'b1) ? 1 : 0;
            end else if (m_busy[i] === 1'b1) begin
                gap_len[i] <= gap_len[i] + 1;
            end
            p_sclk[i] <= m_sclk[i];
            p_mosi[i] <= m_mosi[i];
            p_cs[i]   <= m_cs[i];
        end
    end

    // Reference: frame = {0011, min(floor(code*gain/128), 4095)}, code = signal[31:20].
    function automatic logic [15:0] model(input logic [31:0] s, input logic [7:0] g);
        int v;
        v = int'(s >> 20) * int'(g) / 128;
        if (v > 4095) v = 4095;
        return {4'h3, 12'(v)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
        if (rnd) begin
            ifa.signal = $urandom;
            ifa.gain   = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_tick_a(output int n);
        n = 0;
        do begin step; n++; end while (ifa.sample_tick !== 1'b1 && n < 400);
    endtask

    // Called in the tick cycle: checks one complete frame and the following gap.
    task automatic frame_a(input string tag, input int drop);
        logic [15:0] exp;
        int n0, k;
        exp = model(ifa.signal, ifa.gain);
        n0  = nframes[0];
        step;
        chk({tag, "_start"}, {ifa.cs_n, ifa.mosi}, {1'b0, exp[15]});
        k = 0;
        while (nframes[0] == n0 && k < 300) begin
            step;
            k++;
            if (k == drop) ifa.enable = 1'b0;
        end
        chk({tag, "_frame"}, last_frame[0], exp);
        chk({tag, "_cslow"}, last_len[0], 64);
        chk({tag, "_bits"}, last_bits[0], 16);
        k = 0;
        while (ifa.busy !== 1'b0 && k < 20) begin step; k++; end
        chk({tag, "_gap"}, gap_len[0], 2);
    endtask

    initial begin
        int n, last_tick, r, r0, k, t, c, nb0;
        logic prev;
        logic [15:0] expb;

        rst_a = 1'b1; rst_b = 1'b1;
        ifa.enable = 1'b1; ifa.signal = 32'h8000_0000; ifa.gain = 8'd128;
        ifb.enable = 1'b1; ifb.signal = 32'h8000_0000; ifb.gain = 8'd128;
        step; step;
        chk("rst_a", {ifa.cs_n, ifa.sclk, ifa.mosi, ifa.busy, ifa.sample_tick, ifa.overrun}, 6'b100000);
        chk("rst_b", {ifb.cs_n, ifb.sclk, ifb.mosi, ifb.busy, ifb.sample_tick, ifb.overrun}, 6'b100000);

        // Directed frames with default parameters
        rst_a = 1'b0;
        wait_tick_a(n);
        chk("first_tick", n, 100);
        last_tick = cyc;
        frame_a("unity", -1);
        chk("unity_lit", last_frame[0], 16'h3800);

        ifa.gain = 8'd64;
        wait_tick_a(n);
        chk("period_g64", cyc - last_tick, 100); last_tick = cyc;
        frame_a("g64", -1);
        chk("g64_lit", last_frame[0], 16'h3400);

        ifa.gain = 8'd255; ifa.signal = 32'hFFF0_0000;
        wait_tick_a(n);
        chk("period_sat", cyc - last_tick, 100); last_tick = cyc;
        frame_a("sat", -1);
        chk("sat_lit", last_frame[0], 16'h3FFF);

        ifa.gain = 8'd0;
        wait_tick_a(n);
        chk("period_g0", cyc - last_tick, 100); last_tick = cyc;
        frame_a("g0", -1);
        chk("g0_lit", last_frame[0], 16'h3000);

        // Random samples, inputs re-randomized every cycle (mid-frame changes included)
        rnd = 1'b1;
        repeat (6) begin
            wait_tick_a(n);
            chk("period_rand", cyc - last_tick, 100); last_tick = cyc;
            frame_a("rand", -1);
        end
        rnd = 1'b0;

        // Reset at the 5th sclk rising edge
        wait_tick_a(n);
        r = 0; k = 0; prev = ifa.sclk;
        while (r < 5 && k < 200) begin
            step; k++;
            if (ifa.sclk === 1'b1 && prev === 1'b0) r++;
            prev = ifa.sclk;
        end
        rst_a = 1'b1;
        step;
        chk("midrst_pins", {ifa.cs_n, ifa.sclk, ifa.mosi, ifa.busy}, 4'b1000);
        rst_a = 1'b0;
        r0 = rises[0];
        wait_tick_a(n);
        chk("midrst_tick", n, 100);
        chk("midrst_quiet", rises[0] - r0, 0);
        frame_a("post_rst", -1);

        // Drop enable mid-frame: frame completes, then silence until enable returns
        wait_tick_a(n);
        frame_a("en_drop", 20);
        t = 0; c = 0;
        repeat (150) begin
            step;
            if (ifa.sample_tick !== 1'b0) t++;
            if (ifa.cs_n !== 1'b1) c++;
        end
        chk("en_off_ticks", t, 0);
        chk("en_off_cs", c, 0);
        ifa.enable = 1'b1;
        wait_tick_a(n);
        chk("en_back_tick", n, 100);
        frame_a("en_back", -1);
        chk("a_no_overrun", ifa.overrun, 0);
        chk("a_mosi_stable", viol[0], 0);

        // Overrun instance: period 32 < frame time
        rst_b = 1'b0;
        n = 0;
        do begin step; n++; end while (ifb.sample_tick !== 1'b1 && n < 100);
        chk("b_tick1", n, 32);
        expb = model(ifb.signal, ifb.gain);
        nb0  = nframes[1];
        step;
        chk("b_cs_fall", ifb.cs_n, 0);
        ifb.signal = 32'h4000_0000;
        n = 0;
        do begin step; n++; end while (ifb.sample_tick !== 1'b1 && n < 100);
        chk("b_tick2", n, 31);
        chk("b_pre_ovr", {ifb.overrun, ifb.busy}, 2'b01);
        step;
        chk("b_ovr_set", ifb.overrun, 1);
        k = 0;
        while (nframes[1] == nb0 && k < 300) begin step; k++; end
        chk("b_frame1", last_frame[1], expb);
        chk("b_frame1_len", last_len[1], 64);
        expb = model(ifb.signal, ifb.gain);
        nb0  = nframes[1];
        k = 0;
        while (nframes[1] == nb0 && k < 300) begin step; k++; end
        chk("b_frame2", last_frame[1], expb);
        chk("b_frame2_lit", last_frame[1], 16'h3400);
        chk("b_ovr_sticky", ifb.overrun, 1);
        chk("b_mosi_stable", viol[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
